chebyshev_coeff_sequencer: RTL
==============================

# chebyshev_coeff_sequencer

Control-side counterpart of the sequential Chebyshev computation datapath. Holds the programmable coefficient bank, accepts one input sample per evaluation, and streams the sample plus coefficients c[ORDER]..c[0] (Clenshaw order, one per cycle) to the datapath. It then collects the datapath result and presents it downstream on a valid/ready handshake.

## Interface
- WORD_LENGTH, 16, sample and result width (two's complement fixed point)
- COEFF_LENGTH, 16, coefficient width
- ORDER, 8, polynomial order; bank holds ORDER+1 coefficients; ORDER ≥ 1
- TIMEOUT_CYCLES, 255, result wait limit; used only with the timeout macro
- clock  input  1  single clock, all logic on rising edge
- resetn  input  1  reset, asynchronous, active-low
- coeff_wr_en  input  1  coefficient write strobe
- coeff_wr_addr  input  AW=clog2(ORDER+1)  coefficient index
- coeff_wr_data  input  COEFF_LENGTH  coefficient value
- coeff_wr_err  output  1  one-cycle pulse: write rejected
- in_valid  input  1  sample offered
- in_ready  output  1  sequencer can accept a sample
- in_data  input  WORD_LENGTH  sample x
- data_out  output  WORD_LENGTH  held sample to datapath
- coeff_out  output  COEFF_LENGTH  current coefficient to datapath
- coeff_valid  output  1  coeff_out valid this cycle
- coeff_first  output  1  coeff_out is c[ORDER]
- coeff_last  output  1  coeff_out is c[0]
- result_valid  input  1  datapath result strobe
- result_data  input  WORD_LENGTH  datapath result
- out_valid  output  1  result offered downstream
- out_ready  input  1  downstream accepts
- out_data  output  WORD_LENGTH  result
- out_err  output  1  result is a timeout substitute (qualified by out_valid)

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset → IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready: latch in_data into data_out, load index = ORDER, go ISSUE.
- ISSUE: coeff_valid=1, coeff_out=bank[index], coeff_first=(index==ORDER), coeff_last=(index==0); index decrements each cycle; after index 0 go WAIT. Exactly ORDER+1 consecutive valid cycles, no gaps.
- WAIT: on result_valid capture result_data into out_data, go RESP. result_valid outside WAIT is ignored.
- RESP: out_valid=1, out_data/out_err stable until out_ready; on out_valid&&out_ready go IDLE.
- data_out holds the sample from acceptance until next acceptance.
- Coefficient writes: accepted only in IDLE with coeff_wr_addr ≤ ORDER; bank updates at that edge. Write in other states or with addr > ORDER: bank unchanged, coeff_wr_err pulses next cycle.
- Simultaneous write and sample acceptance in IDLE: write is committed first; the new value is used by this evaluation.
- Reset mid-operation: FSM to IDLE, all outputs to reset values, bank cleared to zero; in-flight evaluation is dropped.

## Timing
- Reset values: in_ready=1 (IDLE decode), all other outputs 0, bank all 0.
- Accept at edge T → coeff_valid high at cycles T+1..T+ORDER+1; WAIT from T+ORDER+2.
- result_valid sampled at edge R → out_valid high from R+1.
- out handshake at edge H → in_ready high from H+1; minimum period per sample = ORDER+4 cycles plus datapath latency.
- All outputs registered except in_ready (state decode).

## Configuration
- CHEBY_SEQ_TIMEOUT_EN defined: WAIT counter counts from 0; when it reaches TIMEOUT_CYCLES without result_valid, go RESP with out_data=0, out_err=1. Counter clears on leaving WAIT.
- Not defined: no counter, WAIT holds indefinitely, out_err tied 0.

## Structure
- Shared package chebyshev_pkg: FSM state enum, clog2-based AW constant function, default width parameters.
- Sub-module chebyshev_coeff_bank: ORDER+1 × COEFF_LENGTH register file, one write port (with range/state gating input), one async read port, async active-low clear.

## Test plan
- ORDER=8, write c[k]=0x0100+k for k=0..8, send x=0x1234 → coeff_out 0x0108..0x0100 on 9 consecutive cycles, first on 0x0108, last on 0x0100, data_out=0x1234 throughout.
- Return result_valid with 0xABCD 5 cycles after last coeff, hold out_ready=0 for 3 cycles → out_valid/out_data=0xABCD stable 4 cycles, in_ready=1 the cycle after handshake.
- Write addr=9 in IDLE, and addr=3 during ISSUE → bank unchanged, coeff_wr_err pulses once each.
- Write c[8]=0x7FFF in the same cycle as sample accept → first coeff_out=0x7FFF.
- Assert resetn=0 during ISSUE index 4 → all outputs 0, in_ready=1 after release, bank reads 0.
- With CHEBY_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=10, no result_valid → out_valid with out_data=0, out_err=1 after 10 WAIT cycles; without macro, still in WAIT after 1000 cycles.

Source files
------------

// File: rtl/chebyshev_pkg.sv
// chebyshev_pkg: shared FSM state type, address width helper and default parameters for the Chebyshev sequencer
package chebyshev_pkg;
  localparam int DEF_WORD_LENGTH = 16;
  localparam int DEF_COEFF_LENGTH = 16;
  localparam int DEF_ORDER = 8;
  localparam int DEF_TIMEOUT_CYCLES = 255;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} seq_state_e;
  function automatic int aw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/chebyshev_coeff_sequencer_if.sv
// chebyshev_coeff_sequencer_if: coefficient write port, sample input, datapath stream and result handshake of the sequencer
interface chebyshev_coeff_sequencer_if #(
  parameter int WORD_LENGTH = chebyshev_pkg::DEF_WORD_LENGTH,
  parameter int COEFF_LENGTH = chebyshev_pkg::DEF_COEFF_LENGTH,
  parameter int ORDER = chebyshev_pkg::DEF_ORDER
);
  localparam int AW = chebyshev_pkg::aw(ORDER + 1);
  logic coeff_wr_en;
  logic [AW-1:0] coeff_wr_addr;
  logic [COEFF_LENGTH-1:0] coeff_wr_data;
  logic coeff_wr_err;
  logic in_valid;
  logic in_ready;
  logic [WORD_LENGTH-1:0] in_data;
  logic [WORD_LENGTH-1:0] data_out;
  logic [COEFF_LENGTH-1:0] coeff_out;
  logic coeff_valid;
  logic coeff_first;
  logic coeff_last;
  logic result_valid;
  logic [WORD_LENGTH-1:0] result_data;
  logic out_valid;
  logic out_ready;
  logic [WORD_LENGTH-1:0] out_data;
  logic out_err;
  modport slave (
    input coeff_wr_en, coeff_wr_addr, coeff_wr_data, in_valid, in_data, result_valid, result_data, out_ready,
    output coeff_wr_err, in_ready, data_out, coeff_out, coeff_valid, coeff_first, coeff_last, out_valid, out_data, out_err
  );
  modport master (
    output coeff_wr_en, coeff_wr_addr, coeff_wr_data, in_valid, in_data, result_valid, result_data, out_ready,
    input coeff_wr_err, in_ready, data_out, coeff_out, coeff_valid, coeff_first, coeff_last, out_valid, out_data, out_err
  );
endinterface

// File: rtl/chebyshev_coeff_bank.sv
// chebyshev_coeff_bank: ORDER+1 coefficient register file, gated write port with write-through async read, async clear
module chebyshev_coeff_bank
  import chebyshev_pkg::*;
#(
  parameter int COEFF_LENGTH = DEF_COEFF_LENGTH,
  parameter int ORDER = DEF_ORDER
) (
  input  logic clock,
  input  logic resetn,
  input  logic wr_en,
  input  logic wr_allow,
  input  logic [aw(ORDER+1)-1:0] wr_addr,
  input  logic [COEFF_LENGTH-1:0] wr_data,
  output logic wr_reject,
  input  logic [aw(ORDER+1)-1:0] rd_addr,
  output logic [COEFF_LENGTH-1:0] rd_data
);
  localparam int AW = aw(ORDER + 1);
  logic [COEFF_LENGTH-1:0] mem_q [ORDER+1];
  logic wr_ok;
  assign wr_ok = wr_en && wr_allow && (wr_addr <= AW'(ORDER));
  assign wr_reject = wr_en && !wr_ok;
  // a write landing in the same cycle as a read of that entry is forwarded so it is seen immediately
  assign rd_data = (wr_ok && wr_addr == rd_addr) ? wr_data : (rd_addr <= AW'(ORDER)) ? mem_q[rd_addr] : '0;
  // storage: cleared by reset, one accepted write per cycle
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) for (int i = 0; i <= ORDER; i++) mem_q[i] <= '0;
    else if (wr_ok) mem_q[wr_addr] <= wr_data;
endmodule

// File: rtl/chebyshev_coeff_sequencer.sv
// chebyshev_coeff_sequencer: streams a sample and c[ORDER]..c[0] to the datapath, returns its result; CHEBY_SEQ_TIMEOUT_EN adds a result timeout
module chebyshev_coeff_sequencer
  import chebyshev_pkg::*;
#(
  parameter int WORD_LENGTH = DEF_WORD_LENGTH,
  parameter int COEFF_LENGTH = DEF_COEFF_LENGTH,
  parameter int ORDER = DEF_ORDER,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic clock,
  input logic resetn,
  chebyshev_coeff_sequencer_if.slave bus
);
  localparam int AW = aw(ORDER + 1);
  localparam logic [AW-1:0] TOP = AW'(ORDER);
  seq_state_e state_q, state_d;
  logic [AW-1:0] idx_q, idx_d, rd_addr;
  logic [WORD_LENGTH-1:0] data_q, data_d, od_q, od_d;
  logic [COEFF_LENGTH-1:0] coeff_q, coeff_d, rd_data;
  logic cv_q, cv_d, first_q, first_d, last_q, last_d;
  logic ov_q, ov_d, oe_q, oe_d, wr_err_q, wr_err_d, wr_reject, timeout;
`ifdef CHEBY_SEQ_TIMEOUT_EN
  localparam int TW = aw(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] cnt_q, cnt_d;
  assign timeout = cnt_q == TW'(TIMEOUT_CYCLES - 1);
  assign cnt_d = (state_q == WAIT && state_d == WAIT) ? cnt_q + 1'b1 : '0;
`else
  assign timeout = 1'b0;
`endif
  chebyshev_coeff_bank #(.COEFF_LENGTH(COEFF_LENGTH), .ORDER(ORDER)) u_bank (
    .clock(clock), .resetn(resetn), .wr_en(bus.coeff_wr_en), .wr_allow(state_q == IDLE),
    .wr_addr(bus.coeff_wr_addr), .wr_data(bus.coeff_wr_data), .wr_reject(wr_reject),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );
  assign bus.in_ready = state_q == IDLE;
  assign bus.data_out = data_q;
  assign bus.coeff_out = coeff_q;
  assign bus.coeff_valid = cv_q;
  assign bus.coeff_first = first_q;
  assign bus.coeff_last = last_q;
  assign bus.out_valid = ov_q;
  assign bus.out_data = od_q;
  assign bus.out_err = oe_q;
  assign bus.coeff_wr_err = wr_err_q;
  // next state: the read port pre-fetches the coefficient shown in the following cycle
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    data_d = data_q;
    coeff_d = coeff_q;
    cv_d = 1'b0;
    first_d = 1'b0;
    last_d = 1'b0;
    ov_d = ov_q;
    od_d = od_q;
    oe_d = oe_q;
    wr_err_d = wr_reject;
    rd_addr = (state_q == ISSUE && idx_q != '0) ? idx_q - 1'b1 : TOP;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        state_d = ISSUE;
        idx_d = TOP;
        data_d = bus.in_data;
        coeff_d = rd_data;
        cv_d = 1'b1;
        first_d = 1'b1;
      end
      ISSUE: if (idx_q == '0) state_d = WAIT;
      else begin
        idx_d = idx_q - 1'b1;
        coeff_d = rd_data;
        cv_d = 1'b1;
        last_d = idx_q == AW'(1);
      end
      WAIT: if (bus.result_valid || timeout) begin
        state_d = RESP;
        ov_d = 1'b1;
        od_d = bus.result_valid ? bus.result_data : '0;
        oe_d = !bus.result_valid;
      end
      RESP: if (bus.out_ready) begin
        state_d = IDLE;
        ov_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and registered outputs, all cleared by reset
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      idx_q <= '0;
      data_q <= '0;
      coeff_q <= '0;
      cv_q <= 1'b0;
      first_q <= 1'b0;
      last_q <= 1'b0;
      ov_q <= 1'b0;
      od_q <= '0;
      oe_q <= 1'b0;
      wr_err_q <= 1'b0;
`ifdef CHEBY_SEQ_TIMEOUT_EN
      cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      data_q <= data_d;
      coeff_q <= coeff_d;
      cv_q <= cv_d;
      first_q <= first_d;
      last_q <= last_d;
      ov_q <= ov_d;
      od_q <= od_d;
      oe_q <= oe_d;
      wr_err_q <= wr_err_d;
`ifdef CHEBY_SEQ_TIMEOUT_EN
      cnt_q <= cnt_d;
`endif
    end
endmodule
